// File: rtl/controls.sv
// Shared control encodings for the load/store path.
// Width codes consumed by the data memory controller.
package controls;
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
endpackage

// File: rtl/dmem_arbiter_pkg.sv
// Types shared by the data-memory arbiter and its bench.
// Arbiter FSM states and access owner tags.
package dmem_arbiter_pkg;
    typedef enum logic {
        CORE_PRI,
        DBG_FORCE
    } arb_state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_DBG
    } owner_t;
endpackage

// File: rtl/dmem_align_check.sv
// Flags a load/store whose address is not aligned to its width.
// Bytes are always aligned.
module dmem_align_check
    import controls::*;
(
    input  logic [1:0] addr_i,
    input  logic [1:0] ls_type_i,
    output logic       misaligned_o
);
    always_comb begin
        misaligned_o = 1'b0;
        unique case (1'b1)
            (ls_type_i == LS_HALF): misaligned_o = addr_i[0];
            (ls_type_i == LS_WORD): misaligned_o = |addr_i;
            default:                misaligned_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter in front of the data memory controller.
// Core has priority; a starved debug port is forced through once.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [1:0]            c_ls_type,
    input  logic                  c_unsigned,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  c_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_ls_type,
    input  logic                  d_unsigned,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  core_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            load_store_type,
    output logic                  load_unsigned,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic c_mis, d_mis;
    logic acc_ok, acc_mis;
    logic acc_we;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            ls_q, ls_d;
    logic                  uns_q, uns_d;
    logic                  rd_q, wr_q;
    owner_t                own_q, own_d;
    logic                  c_err_q, d_err_q;
    logic                  c_rv_q, d_rv_q;

    dmem_align_check u_c_align (
        .addr_i      (c_addr[1:0]),
        .ls_type_i   (c_ls_type),
        .misaligned_o(c_mis)
    );

    dmem_align_check u_d_align (
        .addr_i      (d_addr[1:0]),
        .ls_type_i   (d_ls_type),
        .misaligned_o(d_mis)
    );

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rstn) begin
            if (state_q == DBG_FORCE) begin
                d_gnt = d_req;
                c_gnt = c_req & ~d_req;
            end else begin
                c_gnt = c_req;
                d_gnt = d_req & ~c_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!d_req || d_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        unique case (state_q)
            CORE_PRI:  if (cnt_d == LIMIT) state_d = DBG_FORCE;
            DBG_FORCE: if (!d_req || d_gnt) state_d = CORE_PRI;
            default:   state_d = CORE_PRI;
        endcase
    end

    // The single granted request is steered onto the shared path.
    always_comb begin
        own_d   = d_gnt ? OWN_DBG : OWN_CORE;
        acc_we  = d_gnt ? d_we : c_we;
        acc_mis = d_gnt ? d_mis : c_mis;
        addr_d  = d_gnt ? d_addr : c_addr;
        wdata_d = d_gnt ? d_wdata : c_wdata;
        ls_d    = d_gnt ? d_ls_type : c_ls_type;
        uns_d   = d_gnt ? d_unsigned : c_unsigned;
        acc_ok  = (c_gnt | d_gnt) & ~acc_mis;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= CORE_PRI;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ls_q    <= '0;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            own_q   <= OWN_CORE;
            c_err_q <= 1'b0;
            d_err_q <= 1'b0;
            c_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc_ok) begin
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                ls_q    <= ls_d;
                uns_q   <= uns_d;
            end
            rd_q    <= acc_ok & ~acc_we;
            wr_q    <= acc_ok & acc_we;
            own_q   <= own_d;
            c_err_q <= c_gnt & c_mis;
            d_err_q <= d_gnt & d_mis;
            c_rv_q  <= rd_q & (own_q == OWN_CORE);
            d_rv_q  <= rd_q & (own_q == OWN_DBG);
        end
    end

    // Registered outputs are masked so nothing leaks out while in reset.
    assign mem_read        = rd_q & rstn;
    assign mem_write       = wr_q & rstn;
    assign mem_addr        = rstn ? addr_q : '0;
    assign mem_write_data  = rstn ? wdata_q : '0;
    assign load_store_type = rstn ? ls_q : '0;
    assign load_unsigned   = uns_q & rstn;

    assign c_err    = c_err_q & rstn;
    assign d_err    = d_err_q & rstn;
    assign c_rvalid = c_rv_q & rstn;
    assign d_rvalid = d_rv_q & rstn;
    assign c_rdata  = c_rvalid ? mem_read_data : '0;
    assign d_rdata  = d_rvalid ? mem_read_data : '0;

    assign core_stall = (c_req & ~c_gnt)
                      | (mem_read & (own_q == OWN_CORE));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model.
// Responses are checked by a scoreboard monitor on the falling edge.
module tb_dmem_arbiter;
    import controls::*;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        c_req, c_we, c_unsigned;
    logic [31:0] c_addr, c_wdata;
    logic [1:0]  c_ls_type;
    logic        d_req, d_we, d_unsigned;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_ls_type;
    logic        c_gnt, c_rvalid, c_err;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        core_stall;
    logic [31:0] mem_addr, mem_write_data;
    logic        mem_read, mem_write;
    logic [1:0]  load_store_type;
    logic        load_unsigned;
    logic [31:0] mem_read_data = '0;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        port;
        logic        kind;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_ls_type(c_ls_type),
        .c_unsigned(c_unsigned), .c_gnt(c_gnt),
        .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ls_type(d_ls_type),
        .d_unsigned(d_unsigned), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .core_stall(core_stall),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .load_store_type(load_store_type),
        .load_unsigned(load_unsigned),
        .mem_read_data(mem_read_data)
    );

    // Memory controller model: little-endian, extends on read.
    logic [7:0] mem [0:255];
    bit init_done = 1'b0;

    always @(posedge clk) begin
        logic [7:0] a;
        a = mem_addr[7:0];
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            init_done = 1'b1;
        end else begin
            if (mem_write) begin
                mem[a] = mem_write_data[7:0];
                if (load_store_type != LS_BYTE)
                    mem[a + 8'd1] = mem_write_data[15:8];
                if (load_store_type == LS_WORD) begin
                    mem[a + 8'd2] = mem_write_data[23:16];
                    mem[a + 8'd3] = mem_write_data[31:24];
                end
            end
            if (mem_read) begin
                if (load_store_type == LS_BYTE)
                    mem_read_data <= load_unsigned
                        ? {24'h0, mem[a]}
                        : {{24{mem[a][7]}}, mem[a]};
                else if (load_store_type == LS_HALF)
                    mem_read_data <= load_unsigned
                        ? {16'h0, mem[a + 8'd1], mem[a]}
                        : {{16{mem[a + 8'd1][7]}}, mem[a + 8'd1], mem[a]};
                else
                    mem_read_data <= {mem[a + 8'd3], mem[a + 8'd2],
                                      mem[a + 8'd1], mem[a]};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic mon(input logic port, input logic kind,
                       input logic [31:0] data);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected: port %0d kind %0d data %h",
                     port, kind, data);
        end else begin
            e = sb.pop_front();
            if (e.port == port && e.kind == kind &&
                (kind || e.data === data))
                passed++;
            else
                $display("FAIL response: got port %0d kind %0d data %h expected port %0d kind %0d data %h",
                         port, kind, data, e.port, e.kind, e.data);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (c_rvalid) mon(1'b0, 1'b0, c_rdata);
            if (d_rvalid) mon(1'b1, 1'b0, d_rdata);
            if (c_err)    mon(1'b0, 1'b1, 32'h0);
            if (d_err)    mon(1'b1, 1'b1, 32'h0);
        end
    end

    function automatic exp_t mk(input logic port, input logic kind,
                                input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.kind = kind;
        e.data = data;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] ls, input logic uns);
        c_req = req; c_we = we; c_addr = addr;
        c_wdata = wd; c_ls_type = ls; c_unsigned = uns;
    endtask

    task automatic set_d(input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] ls, input logic uns);
        d_req = req; d_we = we; d_addr = addr;
        d_wdata = wd; d_ls_type = ls; d_unsigned = uns;
    endtask

    task automatic idle();
        set_c(1'b0, 1'b0, 32'h0, 32'h0, LS_WORD, 1'b0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0, LS_WORD, 1'b0);
    endtask

    initial begin
        bit [5:0] cpat;
        rstn = 1'b0;
        idle();
        c_req = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_stall", {31'h0, core_stall}, 32'h1);
        chk("rst_cgnt", {31'h0, c_gnt}, 32'h0);
        chk("rst_dgnt", {31'h0, d_gnt}, 32'h0);
        chk("rst_mrd", {31'h0, mem_read}, 32'h0);
        chk("rst_mwr", {31'h0, mem_write}, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        tick();
        c_req = 1'b0;
        @(negedge clk);
        chk("rst_stall0", {31'h0, core_stall}, 32'h0);
        tick();
        rstn = 1'b1;

        // core store then load of the same word
        tick();
        set_c(1'b1, 1'b1, 32'd80, 32'hF0F0F0F0, LS_WORD, 1'b0);
        @(negedge clk);
        chk("st_cgnt", {31'h0, c_gnt}, 32'h1);
        chk("st_dgnt", {31'h0, d_gnt}, 32'h0);
        tick();
        set_c(1'b1, 1'b0, 32'd80, 32'h0, LS_WORD, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 32'hF0F0F0F0));
        @(negedge clk);
        chk("ld_cgnt", {31'h0, c_gnt}, 32'h1);
        chk("st_mwr", {31'h0, mem_write}, 32'h1);
        chk("st_maddr", mem_addr, 32'd80);
        chk("st_wdata", mem_write_data, 32'hF0F0F0F0);
        tick();
        idle();
        @(negedge clk);
        chk("ld_mrd", {31'h0, mem_read}, 32'h1);
        chk("ld_mwr", {31'h0, mem_write}, 32'h0);
        tick();
        @(negedge clk);
        chk("idle_mrd", {31'h0, mem_read}, 32'h0);
        chk("hold_maddr", mem_addr, 32'd80);

        // contention: debug forced on the fifth cycle
        cpat = 6'b101111;
        for (int i = 0; i < 6; i++) begin
            tick();
            set_c(1'b1, 1'b0, 32'd80, 32'h0, LS_WORD, 1'b0);
            set_d(1'b1, 1'b0, 32'd0, 32'h0, LS_WORD, 1'b0);
            if (cpat[i]) sb.push_back(mk(1'b0, 1'b0, 32'hF0F0F0F0));
            else         sb.push_back(mk(1'b1, 1'b0, 32'h0));
            @(negedge clk);
            chk($sformatf("cont_cgnt%0d", i), {31'h0, c_gnt},
                {31'h0, cpat[i]});
            chk($sformatf("cont_dgnt%0d", i), {31'h0, d_gnt},
                {31'h0, ~cpat[i]});
            if (i == 4)
                chk("cont_stall", {31'h0, core_stall}, 32'h1);
        end
        tick();
        idle();
        tick(); tick();

        // misaligned debug half-load and core word-store
        tick();
        set_d(1'b1, 1'b0, 32'd151, 32'h0, LS_HALF, 1'b0);
        sb.push_back(mk(1'b1, 1'b1, 32'h0));
        @(negedge clk);
        chk("mis_dgnt", {31'h0, d_gnt}, 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("mis_mrd", {31'h0, mem_read}, 32'h0);
        tick();
        set_c(1'b1, 1'b1, 32'd82, 32'hDEADBEEF, LS_WORD, 1'b0);
        sb.push_back(mk(1'b0, 1'b1, 32'h0));
        @(negedge clk);
        chk("mis_cgnt", {31'h0, c_gnt}, 32'h1);
        chk("mis_mrd2", {31'h0, mem_read}, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("mis_mwr", {31'h0, mem_write}, 32'h0);
        tick(); tick();

        // stall while debug is forced
        for (int i = 0; i < 5; i++) begin
            tick();
            set_c(1'b1, 1'b0, 32'd0, 32'h0, LS_WORD, 1'b0);
            set_d(1'b1, 1'b1, 32'h40, 32'h12345678, LS_WORD, 1'b0);
            if (i < 4) sb.push_back(mk(1'b0, 1'b0, 32'h0));
            @(negedge clk);
            if (i < 4) chk($sformatf("stl_cgnt%0d", i),
                           {31'h0, c_gnt}, 32'h1);
        end
        chk("frc_dgnt", {31'h0, d_gnt}, 32'h1);
        chk("frc_cgnt", {31'h0, c_gnt}, 32'h0);
        chk("frc_stall", {31'h0, core_stall}, 32'h1);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0, LS_WORD, 1'b0);
        set_c(1'b1, 1'b0, 32'h40, 32'h0, LS_WORD, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 32'h12345678));
        @(negedge clk);
        chk("aft_cgnt", {31'h0, c_gnt}, 32'h1);
        chk("aft_stall", {31'h0, core_stall}, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("pend_stall", {31'h0, core_stall}, 32'h1);
        tick();
        tick();
        @(negedge clk);
        chk("done_stall", {31'h0, core_stall}, 32'h0);

        // byte lane with signed and unsigned loads
        tick();
        set_d(1'b1, 1'b1, 32'd22, 32'h000000F0, LS_BYTE, 1'b0);
        @(negedge clk);
        chk("bst_dgnt", {31'h0, d_gnt}, 32'h1);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0, LS_WORD, 1'b0);
        set_c(1'b1, 1'b0, 32'd22, 32'h0, LS_BYTE, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 32'hFFFFFFF0));
        @(negedge clk);
        chk("bls_cgnt", {31'h0, c_gnt}, 32'h1);
        tick();
        set_c(1'b1, 1'b0, 32'd22, 32'h0, LS_BYTE, 1'b1);
        sb.push_back(mk(1'b0, 1'b0, 32'h000000F0));
        @(negedge clk);
        chk("blu_cgnt", {31'h0, c_gnt}, 32'h1);
        tick();
        idle();
        tick(); tick();

        // reset in flight, with debug already forced
        for (int i = 0; i < 4; i++) begin
            tick();
            set_c(1'b1, 1'b0, 32'd80, 32'h0, LS_WORD, 1'b0);
            set_d(1'b1, 1'b0, 32'd0, 32'h0, LS_WORD, 1'b0);
            if (i < 2) sb.push_back(mk(1'b0, 1'b0, 32'hF0F0F0F0));
        end
        tick();
        rstn = 1'b0;
        c_req = 1'b0;
        @(negedge clk);
        chk("pre_state", 32'(dut.state_q), 32'(DBG_FORCE));
        chk("rmid_dgnt", {31'h0, d_gnt}, 32'h0);
        chk("rmid_mrd", {31'h0, mem_read}, 32'h0);
        chk("rmid_stall", {31'h0, core_stall}, 32'h0);
        tick();
        rstn = 1'b1;
        idle();
        @(negedge clk);
        chk("post_state", 32'(dut.state_q), 32'(CORE_PRI));
        chk("post_cnt", 32'(dut.cnt_q), 32'h0);
        chk("post_mrd", {31'h0, mem_read}, 32'h0);
        chk("post_mwr", {31'h0, mem_write}, 32'h0);
        chk("post_maddr", mem_addr, 32'h0);
        chk("post_crv", {31'h0, c_rvalid}, 32'h0);
        tick(); tick(); tick();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameters, one per line:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before debug is forced.

REQ-002 The block SHALL have ports, one per line (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  synchronous, active-low reset.
- c_req / d_req  in  1  core / debug request; held until the matching gnt.
- c_we / d_we  in  1  request is a store (1) or load (0).
- c_addr / d_addr  in  ADDR_WIDTH  byte address.
- c_wdata / d_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- c_ls_type / d_ls_type  in  2  LS_BYTE, LS_HALF or LS_WORD encoding.
- c_unsigned / d_unsigned  in  1  zero-extend load.
- c_gnt / d_gnt  out  1  request accepted this cycle.
- c_rvalid / d_rvalid  out  1  load data valid, one-cycle pulse.
- c_rdata / d_rdata  out  DATA_WIDTH  load data, qualified by rvalid.
- c_err / d_err  out  1  misaligned-access pulse.
- core_stall  out  1  freezes the pipeline MEM stage.
- mem_addr  out  ADDR_WIDTH  to data_memory_controller.
- mem_write_data  out  DATA_WIDTH  to data_memory_controller.
- mem_read / mem_write  out  1  to data_memory_controller.
- load_store_type  out  2  to data_memory_controller.
- load_unsigned  out  1  to data_memory_controller.
- mem_read_data  in  DATA_WIDTH  from data_memory_controller; valid one cycle after mem_read is driven.

Function
REQ-003 Arbitration SHALL be combinational in cycle N, with at most one gnt per cycle.
REQ-004 A granted request SHALL drive registered mem_* signals in cycle N+1. Load data SHALL appear on the owner's rdata with its rvalid in cycle N+2.
REQ-005 The arbiter SHALL issue back-to-back, one access per cycle. An owner tag SHALL travel with each access through a 2-stage pipeline so rvalid reaches the correct port.
REQ-006 The FSM SHALL have states CORE_PRI and DBG_FORCE.
- In CORE_PRI, if both requests are active, the core wins.
- In DBG_FORCE, debug wins whenever d_req=1.
REQ-007 The starvation counter SHALL behave as follows.
- It increments each cycle with d_req=1 and d_gnt=0.
- It clears on d_gnt or on d_req=0.
- When it reaches STARVE_LIMIT, the FSM moves to DBG_FORCE.
REQ-008 DBG_FORCE SHALL return to CORE_PRI and clear the counter on d_gnt, or on d_req=0.
REQ-009 Misalignment SHALL be judged as follows.
- LS_HALF with addr[0]=1 is misaligned.
- LS_WORD with addr[1:0]≠0 is misaligned.
- LS_BYTE is never misaligned.
REQ-010 A misaligned request SHALL still be granted. It SHALL NOT drive mem_read or mem_write, SHALL pulse that port's err in N+1, and SHALL produce no rvalid.
REQ-011 core_stall SHALL equal (c_req AND NOT c_gnt) OR (a core load issued whose c_rvalid has not yet pulsed).
REQ-012 In cycles with no valid access, mem_read and mem_write SHALL be 0. mem_addr and mem_write_data SHALL hold their last values.
REQ-013 rdata SHALL pass mem_read_data through unchanged; extension is done by the memory controller.
REQ-014 A requester dropping req before gnt SHALL abort that request with no side effects.

Reset
REQ-015 When rstn=0 at a rising clk, the FSM SHALL enter CORE_PRI and the counter SHALL clear.
REQ-016 During that reset, every output SHALL be 0 except combinational core_stall, which SHALL reflect c_req.
REQ-017 A reset mid-operation SHALL discard all in-flight accesses: no rvalid and no err SHALL follow, and the memory SHALL NOT be written in the cycle after reset.

Structure
REQ-018 A shared package SHALL hold the arb_state_t enum (CORE_PRI, DBG_FORCE) and the owner_t enum (OWN_CORE, OWN_DBG).
REQ-019 The LS_* encodings SHALL be taken from controls.sv and not redefined.
REQ-020 Misalignment detection SHALL be a sub-module dmem_align_check (addr[1:0], ls_type -> misaligned), instantiated once per port.

Verification
REQ-021 Core store then core load:
- Stimulus: c_req with store LS_WORD 0xF0F0F0F0 at addr 80, next cycle a load of addr 80.
- Response: c_rvalid two cycles after the load's gnt with c_rdata=0xF0F0F0F0; d_* idle.
REQ-022 Contention:
- Stimulus: c_req and d_req held continuously, STARVE_LIMIT=4.
- Response: core granted in cycles 0–3; debug granted in cycle 4; core granted again in cycle 5.
REQ-023 Misaligned access:
- Stimulus: d_req load LS_HALF at addr 151.
- Response: d_gnt, d_err pulse in N+1, mem_read=0 throughout, no d_rvalid.
REQ-024 Stall:
- Stimulus: core load while debug is forced.
- Response: core_stall=1 until c_rvalid, then 0 the following cycle if c_req=0.
REQ-025 Reset mid-load:
- Stimulus: rstn=0 in cycle N+1 of a core load.
- Response: no c_rvalid, all outputs 0, FSM=CORE_PRI, counter=0.
REQ-026 Byte lane:
- Stimulus: debug store LS_BYTE 0xF0 at addr 22, then core load LS_BYTE at addr 22 with c_unsigned=0, then with c_unsigned=1.
- Response: c_rdata=0xFFFFFFF0 then 0x000000F0.
